// File: rtl/uio_link_pkg.sv
// Shared definitions for both ends of the 8-bit uio req/ack byte link.
package uio_link_pkg;

  localparam int BYTE_W           = 8;
  localparam int LINK_DEPTH       = 4;
  localparam int LINK_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    HOLD     = 2'd2
  } rdr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is left unreset, only pointers and count reset.
module sync_fifo
  import uio_link_pkg::*;
#(
  parameter int DEPTH  = LINK_DEPTH,
  parameter int DATA_W = BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uio_byte_reader.sv
// Receive side of the uio byte link: synchronises req, captures one byte per req phase, acks,
// and streams buffered bytes to the core on a valid/ready interface.
module uio_byte_reader
  import uio_link_pkg::*;
#(
  parameter int DEPTH       = LINK_DEPTH,
  parameter int SYNC_STAGES = LINK_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BYTE_W-1:0]        bus_data_in,
  input  logic                     bus_req_in,
  output logic                     bus_ack_out,
  output logic [BYTE_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     stall
);

  rdr_state_t              state;
  logic [SYNC_STAGES-1:0]  req_sync;
  logic [SYNC_STAGES-1:0]  sync_vld;
  logic                    req_s;
  logic                    sync_primed;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic [BYTE_W-1:0]       fifo_head;

  // Stage boundary: req synchroniser. sync_vld marks when req_s reflects the pin rather than reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync <= '0;
      sync_vld <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], bus_req_in};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign req_s       = req_sync[SYNC_STAGES-1];
  assign sync_primed = sync_vld[SYNC_STAGES-1];
  assign push        = (state == IDLE) && req_s && !fifo_full;

  // Stage boundary: handshake FSM. WAIT_LOW needs a genuine low req, not the reset value of the chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_LOW;
      bus_ack_out <= 1'b0;
      stall       <= 1'b0;
    end else begin
      case (state)
        WAIT_LOW: begin
          bus_ack_out <= 1'b0;
          stall       <= 1'b0;
          if (sync_primed && !req_s) state <= IDLE;
        end
        IDLE: begin
          if (req_s && !fifo_full) begin
            bus_ack_out <= 1'b1;
            stall       <= 1'b0;
            state       <= HOLD;
          end else begin
            stall <= req_s;
          end
        end
        HOLD: begin
          stall <= 1'b0;
          if (!req_s) begin
            bus_ack_out <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          bus_ack_out <= 1'b0;
          stall       <= 1'b0;
          state       <= WAIT_LOW;
        end
      endcase
    end
  end

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus_data_in),
    .pop       (out_ready),
    .rd_data   (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head : '0;

endmodule

// File: tb/tb_uio_byte_reader.sv
// Directed bench for uio_byte_reader: handshake latency, full/stall, streaming, reset mid-handshake.
module tb_uio_byte_reader;

  logic       clk;
  logic       rst;
  logic [7:0] bus_data_in;
  logic       bus_req_in;
  logic       bus_ack_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_count;
  logic       stall;

  int checks = 0;
  int errors = 0;

  logic       mon_en = 1'b0;
  logic [7:0] seen[$];
  int         maxcnt = 0;

  uio_byte_reader #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_data_in (bus_data_in),
    .bus_req_in  (bus_req_in),
    .bus_ack_out (bus_ack_out),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
      if (out_valid && out_ready) seen.push_back(out_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ack(input logic level, input string tag);
    int n = 0;
    while (bus_ack_out !== level && n < 20) begin
      step();
      n++;
    end
    check(tag, (n < 20) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic hs(input logic [7:0] d);
    bus_data_in = d;
    bus_req_in  = 1'b1;
    wait_ack(1'b1, "hs_ack_rise");
    bus_req_in = 1'b0;
    wait_ack(1'b0, "hs_ack_fall");
  endtask

  task automatic pop_check(input logic [7:0] exp, input string tag);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, {24'b0, out_data}, {24'b0, exp});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus_req_in  = 1'b0;
    bus_data_in = 8'h00;
    out_ready   = 1'b0;
    #1;
    check("rst_ack",   {31'b0, bus_ack_out}, 32'd0);
    check("rst_valid", {31'b0, out_valid},   32'd0);
    check("rst_data",  {24'b0, out_data},    32'd0);
    check("rst_count", {29'b0, fifo_count},  32'd0);
    check("rst_stall", {31'b0, stall},       32'd0);
    step();
    step();
    rst = 1'b0;
    repeat (5) step();

    // Test 1: single handshake latency
    bus_data_in = 8'hA5;
    bus_req_in  = 1'b1;
    step();
    check("t1_ack_e1", {31'b0, bus_ack_out}, 32'd0);
    step();
    check("t1_ack_e2", {31'b0, bus_ack_out}, 32'd0);
    step();
    check("t1_ack_e3",  {31'b0, bus_ack_out}, 32'd1);
    check("t1_valid",   {31'b0, out_valid},   32'd1);
    check("t1_data",    {24'b0, out_data},    32'h A5);
    check("t1_count",   {29'b0, fifo_count},  32'd1);
    bus_req_in = 1'b0;
    step();
    step();
    check("t1_ackfall_e2", {31'b0, bus_ack_out}, 32'd1);
    step();
    check("t1_ackfall_e3", {31'b0, bus_ack_out}, 32'd0);
    pop_check(8'hA5, "t1_pop");
    check("t1_count_after", {29'b0, fifo_count}, 32'd0);

    // Test 2: fill, stall, pop releases stall
    for (int i = 1; i <= 4; i++) hs(8'(i));
    check("t2_count_full", {29'b0, fifo_count}, 32'd4);
    bus_data_in = 8'h05;
    bus_req_in  = 1'b1;
    repeat (4) step();
    check("t2_ack_blocked", {31'b0, bus_ack_out}, 32'd0);
    check("t2_stall",       {31'b0, stall},       32'd1);
    check("t2_count_hold",  {29'b0, fifo_count},  32'd4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_count_popped", {29'b0, fifo_count}, 32'd3);
    check("t2_head_after",   {24'b0, out_data},   32'h02);
    check("t2_ack_pop_edge", {31'b0, bus_ack_out}, 32'd0);
    step();
    check("t2_ack_capture",  {31'b0, bus_ack_out}, 32'd1);
    check("t2_stall_clear",  {31'b0, stall},       32'd0);
    check("t2_count_refill", {29'b0, fifo_count},  32'd4);
    bus_req_in = 1'b0;
    wait_ack(1'b0, "t2_ack_fall");
    pop_check(8'h02, "t2_ord0");
    pop_check(8'h03, "t2_ord1");
    pop_check(8'h04, "t2_ord2");
    pop_check(8'h05, "t2_ord3");
    check("t2_count_empty", {29'b0, fifo_count}, 32'd0);

    // Test 3: streaming with out_ready held high
    seen.delete();
    maxcnt    = 0;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    for (int i = 0; i < 8; i++) hs(8'h10 + 8'(i));
    repeat (3) step();
    mon_en    = 1'b0;
    out_ready = 1'b0;
    check("t3_nbytes", seen.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < seen.size()) check($sformatf("t3_byte%0d", i), {24'b0, seen[i]}, 32'h10 + i);
    end
    check("t3_maxcnt_le1", (maxcnt <= 1) ? 32'd1 : 32'd0, 32'd1);
    check("t3_count_end", {29'b0, fifo_count}, 32'd0);

    // Test 4: push and pop on the same edge at count 2
    hs(8'h20);
    hs(8'h21);
    check("t4_count_pre", {29'b0, fifo_count}, 32'd2);
    bus_data_in = 8'h22;
    bus_req_in  = 1'b1;
    step();
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_ack",       {31'b0, bus_ack_out}, 32'd1);
    check("t4_count_same", {29'b0, fifo_count}, 32'd2);
    check("t4_head",      {24'b0, out_data},    32'h21);
    bus_req_in = 1'b0;
    wait_ack(1'b0, "t4_ack_fall");
    pop_check(8'h21, "t4_ord0");
    pop_check(8'h22, "t4_ord1");
    check("t4_count_empty", {29'b0, fifo_count}, 32'd0);

    // Test 5: reset while in HOLD with req held
    bus_data_in = 8'h77;
    bus_req_in  = 1'b1;
    wait_ack(1'b1, "t5_ack_rise");
    check("t5_count_pre", {29'b0, fifo_count}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_ack_async",   {31'b0, bus_ack_out}, 32'd0);
    check("t5_count_async", {29'b0, fifo_count},  32'd0);
    check("t5_valid_async", {31'b0, out_valid},   32'd0);
    step();
    rst = 1'b0;
    repeat (8) step();
    check("t5_no_recapture_ack",   {31'b0, bus_ack_out}, 32'd0);
    check("t5_no_recapture_count", {29'b0, fifo_count},  32'd0);
    bus_req_in = 1'b0;
    repeat (5) step();
    hs(8'h3C);
    check("t5_count_cap", {29'b0, fifo_count}, 32'd1);
    check("t5_data_cap",  {24'b0, out_data},   32'h3C);
    repeat (5) step();
    check("t5_count_once", {29'b0, fifo_count}, 32'd1);
    pop_check(8'h3C, "t5_pop");

    // Test 6: pop attempts while empty are ignored
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t6_valid%0d", i), {31'b0, out_valid}, 32'd0);
      check($sformatf("t6_count%0d", i), {29'b0, fifo_count}, 32'd0);
    end
    out_ready = 1'b0;
    hs(8'h5A);
    check("t6_count_after", {29'b0, fifo_count}, 32'd1);
    check("t6_data_after",  {24'b0, out_data},   32'h5A);
    pop_check(8'h5A, "t6_pop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
